// File: rtl/word_axi_burst_writer.sv
// Drains a FWFT word FIFO into DDR as AXI4 INCR write bursts over a circular address region.
// Define WR_STATS_EN to add burst_done_count_o / resp_err_count_o statistics outputs.
module word_axi_burst_writer #(
    parameter int unsigned           DATA_WIDTH   = 128,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           BURST_LEN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0100_0000,
    parameter int unsigned           COUNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] word_fifo_dout_i,
    input  logic                  word_fifo_empty_i,
    input  logic [COUNT_W-1:0]    word_fifo_count_i,
    output logic                  word_fifo_rd_en_o,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
    output logic [7:0]            m_axi_awlen_o,
    output logic [2:0]            m_axi_awsize_o,
    output logic [1:0]            m_axi_awburst_o,
    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,
    output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
    output logic [15:0]           m_axi_wstrb_o,
    output logic                  m_axi_wlast_o,
    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,
    input  logic [1:0]            m_axi_bresp_i,
    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o,
`ifdef WR_STATS_EN
    output logic [31:0]           burst_done_count_o,
    output logic [15:0]           resp_err_count_o,
`endif
    output logic                  busy_o,
    output logic                  wr_error_o
);

    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    localparam logic [ADDR_WIDTH-1:0] BurstBytes = ADDR_WIDTH'(BURST_LEN * 16);
    localparam logic [ADDR_WIDTH-1:0] RegionEnd  = BASE_ADDR + REGION_BYTES;
    localparam logic [7:0]            LastBeat   = 8'(BURST_LEN - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]              beat_q;
    logic                    awvalid_q, wvalid_q, wlast_q, bready_q, busy_q, wr_error_q;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    start_burst;
    logic                    b_done;

    assign next_addr   = awaddr_q + BurstBytes;
    assign start_burst = enable_i && (32'(word_fifo_count_i) >= BURST_LEN);
    assign b_done      = (state_q == StB) && m_axi_bvalid_i;

    // Emptiness is not consulted: the count contract guarantees a full burst is buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            awaddr_q   <= BASE_ADDR;
            beat_q     <= 8'd0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_burst) begin
                        state_q   <= StAw;
                        awvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StAw: begin
                    if (m_axi_awready_i) begin
                        state_q   <= StW;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (LastBeat == 8'd0);
                    end
                end
                StW: begin
                    if (m_axi_wready_i) begin
                        if (wlast_q) begin
                            state_q  <= StB;
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            beat_q   <= 8'd0;
                            bready_q <= 1'b1;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            wlast_q <= ((beat_q + 8'd1) == LastBeat);
                        end
                    end
                end
                StB: begin
                    if (m_axi_bvalid_i) begin
                        state_q  <= StIdle;
                        bready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        awaddr_q <= (next_addr == RegionEnd) ? BASE_ADDR : next_addr;
                        if (m_axi_bresp_i != 2'b00) begin
                            wr_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WR_STATS_EN
    logic [31:0] burst_done_q;
    logic [15:0] resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_done_q <= 32'd0;
            resp_err_q   <= 16'd0;
        end else if (b_done) begin
            burst_done_q <= burst_done_q + 32'd1;
            if ((m_axi_bresp_i != 2'b00) && (resp_err_q != 16'hFFFF)) begin
                resp_err_q <= resp_err_q + 16'd1;
            end
        end
    end

    assign burst_done_count_o = burst_done_q;
    assign resp_err_count_o   = resp_err_q;
`else
    // Statistics counters are not built in this configuration.
    logic unused_stats;
    assign unused_stats = b_done;
`endif

    logic unused_empty;
    assign unused_empty = word_fifo_empty_i;

    assign word_fifo_rd_en_o = wvalid_q && m_axi_wready_i;
    assign m_axi_awaddr_o    = awaddr_q;
    assign m_axi_awlen_o     = LastBeat;
    assign m_axi_awsize_o    = 3'b100;
    assign m_axi_awburst_o   = 2'b01;
    assign m_axi_awvalid_o   = awvalid_q;
    assign m_axi_wdata_o     = word_fifo_dout_i;
    assign m_axi_wstrb_o     = 16'hFFFF;
    assign m_axi_wlast_o     = wlast_q;
    assign m_axi_wvalid_o    = wvalid_q;
    assign m_axi_bready_o    = bready_q;
    assign busy_o            = busy_q;
    assign wr_error_o        = wr_error_q;

endmodule
